// File: rtl/pipe_wb_stage.sv
// Write-back stage: GPR write-data select, architectural HI/LO, a one-entry
// forward buffer for decode, and a wrapping retire counter.
module pipe_wb_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             w_rf,
   input  logic             w_hi,
   input  logic             w_lo,
   input  logic [2:0]       rfsource,
   input  logic [1:0]       hisource,
   input  logic [1:0]       losource,
   input  logic [4:0]       rn,
   input  logic [31:0]      alu,
   input  logic [31:0]      a,
   input  logic [31:0]      dm,
   input  logic [31:0]      pc4,
   input  logic [31:0]      counter,
   input  logic [31:0]      cp0,
   input  logic [31:0]      hi_in,
   input  logic [31:0]      lo_in,
   input  logic [31:0]      muler_hi,
   input  logic [31:0]      muler_lo,
   input  logic [31:0]      q,
   input  logic [31:0]      r,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [31:0]      hi_out,
   output logic [31:0]      lo_out,
   output logic             fwd_valid,
   output logic [4:0]       fwd_addr,
   output logic [31:0]      fwd_data,
   output logic [CNT_W-1:0] retire_cnt
);

   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic             r_fwd_valid;
   logic [4:0]       r_fwd_addr;
   logic [31:0]      r_fwd_data;
   logic [CNT_W-1:0] r_retire_cnt;

   logic             w_we;
   logic [31:0]      w_wdata;
   logic [31:0]      w_hi_next;
   logic [31:0]      w_lo_next;
   logic             w_any_write;

   // $0 is hardwired zero, so a write to it never reaches the register file
   assign w_we        = w_rf & (rn != 5'd0);
   assign w_any_write = w_rf | w_hi | w_lo;

   // mfhi/mflo read the registered value, i.e. HI/LO before this cycle's update
   always_comb begin
      w_wdata = alu;
      case (rfsource)
         3'd0: w_wdata = alu;
         3'd1: w_wdata = dm;
         3'd2: w_wdata = pc4;
         3'd3: w_wdata = r_hi;
         3'd4: w_wdata = r_lo;
         3'd5: w_wdata = counter;
         3'd6: w_wdata = cp0;
         3'd7: w_wdata = muler_lo;
         default: w_wdata = alu;
      endcase
   end

   always_comb begin
      w_hi_next = hi_in;
      case (hisource)
         2'd0: w_hi_next = hi_in;
         2'd1: w_hi_next = muler_hi;
         2'd2: w_hi_next = r;
         2'd3: w_hi_next = a;
         default: w_hi_next = hi_in;
      endcase
   end

   always_comb begin
      w_lo_next = lo_in;
      case (losource)
         2'd0: w_lo_next = lo_in;
         2'd1: w_lo_next = muler_lo;
         2'd2: w_lo_next = q;
         2'd3: w_lo_next = a;
         default: w_lo_next = lo_in;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (w_hi) r_hi <= w_hi_next;
         if (w_lo) r_lo <= w_lo_next;
      end
   end

   // Address/data hold on a bubble so only the valid bit needs watching
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fwd_valid <= 1'b0;
         r_fwd_addr  <= '0;
         r_fwd_data  <= '0;
      end else begin
         r_fwd_valid <= w_we;
         if (w_we) begin
            r_fwd_addr <= rn;
            r_fwd_data <= w_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              r_retire_cnt <= '0;
      else if (w_any_write) r_retire_cnt <= r_retire_cnt + 1'b1;
   end

   assign rf_we      = w_we;
   assign rf_waddr   = rn;
   assign rf_wdata   = w_wdata;
   assign hi_out     = r_hi;
   assign lo_out     = r_lo;
   assign fwd_valid  = r_fwd_valid;
   assign fwd_addr   = r_fwd_addr;
   assign fwd_data   = r_fwd_data;
   assign retire_cnt = r_retire_cnt;

endmodule
